// File: rtl/datapath_with_memory_legv8_core.sv
// ---------------------------------------------------------------------------
// datapath_with_memory_legv8_core
//
// Single-cycle LEGv8-style datapath: a 32x64 register file (X31 hard-wired to
// zero), a 64-bit function unit with V/C/N/Z status, and a 256x64 word RAM.
// All units share one tri-state data bus, and that bus is the register-file
// write source.
//
// Ports
//   ControlWord [31:0] in  : per-cycle microoperation
//                             [4:0] DA, [9:5] SA, [14:10] SB, [15] RW, [16] BS,
//                             [21:17] FS, [22] C0, [23] MEM_EN, [24] EN_ALU,
//                             [25] MW, [31:26] reserved
//   data        [63:0] io  : shared bus (F, RAM read data, X[SB], or high-Z)
//   address     [31:0] out : memory address = F[31:0]
//   reset              in  : synchronous, active-low
//   clock              in  : rising-edge clock
//   constant    [63:0] in  : immediate operand for the B mux
//   status      [3:0]  out : {V, C, N, Z} of the current function result
//   r0 .. r7    [15:0] out : low 16 bits of X0 .. X7
// ---------------------------------------------------------------------------
module datapath_with_memory_legv8_core (
  input  logic [31:0] ControlWord,
  inout  wire  [63:0] data,
  output logic [31:0] address,
  input  logic        reset,
  input  logic        clock,
  input  logic [63:0] constant,
  output logic [3:0]  status,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7
);

  // Control word fields
  logic [4:0]  da, sa, sb, fs;
  logic        rw, bs, c0, mem_en, en_alu, mw;

  assign da     = ControlWord[4:0];
  assign sa     = ControlWord[9:5];
  assign sb     = ControlWord[14:10];
  assign rw     = ControlWord[15];
  assign bs     = ControlWord[16];
  assign fs     = ControlWord[21:17];
  assign c0     = ControlWord[22];
  assign mem_en = ControlWord[23];
  assign en_alu = ControlWord[24];
  assign mw     = ControlWord[25];

  // Reserved control bits are intentionally ignored
  logic unused_reserved;
  assign unused_reserved = ^ControlWord[31:26];

  // Register file: only X0..X30 have storage; X31 reads as zero
  logic [63:0] regs [0:30];
  logic [63:0] a_data, b_data;

  assign a_data = (sa == 5'd31) ? 64'd0 : regs[sa];
  assign b_data = (sb == 5'd31) ? 64'd0 : regs[sb];

  // Reset clears the file and takes priority over RW; writes to X31 vanish
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 31; i++) begin
        regs[i] <= 64'd0;
      end
    end else if (rw && (da != 5'd31)) begin
      regs[da] <= data;
    end
  end

  // Operand selection and optional inversion
  logic [63:0] b_mux, a_op, b_op;

  assign b_mux = bs ? constant : b_data;
  assign a_op  = fs[1] ? ~a_data : a_data;
  assign b_op  = fs[0] ? ~b_mux : b_mux;

  // Adder is kept one bit wider so its carry out is directly available
  logic [64:0] sum_full;

  assign sum_full = {1'b0, a_op} + {1'b0, b_op} + {64'd0, c0};

  // Function select; carry and overflow only mean something for the adder
  logic [63:0] f;
  logic        carry, ovf;

  always_comb begin
    f     = 64'd0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (fs[4:2])
      3'b000: f = a_op & b_op;
      3'b001: f = a_op | b_op;
      3'b010: begin
        f     = sum_full[63:0];
        carry = sum_full[64];
        ovf   = (a_op[63] == b_op[63]) && (sum_full[63] != a_op[63]);
      end
      3'b011: f = a_op ^ b_op;
      3'b100: f = a_op << b_op[5:0];
      3'b101: f = a_op >> b_op[5:0];
      default: f = a_op;
    endcase
  end

  assign status  = {ovf, carry, f[63], (f == 64'd0)};
  assign address = f[31:0];

  // Word RAM, no reset, so stores still land during a reset cycle
  logic [63:0] ram [0:255];
  logic [63:0] ram_q;

  assign ram_q = ram[address[7:0]];

  always_ff @(posedge clock) begin
    if (mem_en && mw) begin
      ram[address[7:0]] <= b_data;
    end
  end

  // Bus driver priority: function result, RAM load, store data, then release
  logic        bus_en;
  logic [63:0] bus_val;

  always_comb begin
    bus_en  = 1'b0;
    bus_val = 64'd0;
    if (en_alu) begin
      bus_en  = 1'b1;
      bus_val = f;
    end else if (mem_en && !mw) begin
      bus_en  = 1'b1;
      bus_val = ram_q;
    end else if (mem_en && mw) begin
      bus_en  = 1'b1;
      bus_val = b_data;
    end
  end

  assign data = bus_en ? bus_val : 64'bz;

  assign r0 = regs[0][15:0];
  assign r1 = regs[1][15:0];
  assign r2 = regs[2][15:0];
  assign r3 = regs[3][15:0];
  assign r4 = regs[4][15:0];
  assign r5 = regs[5][15:0];
  assign r6 = regs[6][15:0];
  assign r7 = regs[7][15:0];

endmodule

// File: tb/tb_datapath_with_memory_legv8_core.sv
// ---------------------------------------------------------------------------
// tb_datapath_with_memory_legv8_core
//
// Self-checking bench: a directed vector table for the reference program, a
// few hand-written multi-cycle sequences (reset vs. store, external bus
// write), then randomized control words compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_datapath_with_memory_legv8_core;

  logic        clock;
  logic        reset;
  logic [31:0] control_word;
  logic [63:0] constant_k;
  wire  [63:0] data_bus;
  logic [31:0] address;
  logic [3:0]  status;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

  logic        tb_drive_en;
  logic [63:0] tb_drive_val;

  assign data_bus = tb_drive_en ? tb_drive_val : 64'bz;

  datapath_with_memory_legv8_core dut (
    .ControlWord(control_word),
    .data(data_bus),
    .address(address),
    .reset(reset),
    .clock(clock),
    .constant(constant_k),
    .status(status),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .r4(r4), .r5(r5), .r6(r6), .r7(r7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] rv [0:7];
  assign rv[0] = r0;
  assign rv[1] = r1;
  assign rv[2] = r2;
  assign rv[3] = r3;
  assign rv[4] = r4;
  assign rv[5] = r5;
  assign rv[6] = r6;
  assign rv[7] = r7;

  int passes;
  int checks;

  // Behavioural model state
  logic [63:0] mx   [0:31];
  logic [63:0] mram [0:255];
  bit          mvalid [0:255];

  // Model's view of the current cycle
  logic [31:0] e_cw;
  logic        e_rst;
  logic [63:0] e_f, e_bus, e_rb;
  logic [3:0]  e_stat;
  logic        e_drive;

  function automatic logic [31:0] mk_cw(input int da, input int sa, input int sb,
                                        input int rw, input int bs, input int fs,
                                        input int c0, input int men, input int ealu,
                                        input int mw);
    logic [31:0] cw;
    cw        = 32'd0;
    cw[4:0]   = da[4:0];
    cw[9:5]   = sa[4:0];
    cw[14:10] = sb[4:0];
    cw[15]    = rw[0];
    cw[16]    = bs[0];
    cw[21:17] = fs[4:0];
    cw[22]    = c0[0];
    cw[23]    = men[0];
    cw[24]    = ealu[0];
    cw[25]    = mw[0];
    return cw;
  endfunction

  // Evaluates the function unit and bus from the rules, using model registers
  task automatic modelComb(input logic [31:0] cw, input logic [63:0] k, input logic [63:0] ext);
    logic [63:0] ra, bm, ap, bp;
    logic [64:0] u_sum, s_sum;
    logic [4:0]  fs;
    logic        c, v;
    fs   = cw[21:17];
    ra   = mx[cw[9:5]];
    e_rb = mx[cw[14:10]];
    bm   = cw[16] ? k : e_rb;
    ap   = fs[1] ? ~ra : ra;
    bp   = fs[0] ? ~bm : bm;
    c    = 1'b0;
    v    = 1'b0;
    case (fs[4:2])
      3'd0: e_f = ap & bp;
      3'd1: e_f = ap | bp;
      3'd2: begin
        u_sum = {1'b0, ap} + {1'b0, bp} + 65'(cw[22]);
        s_sum = {ap[63], ap} + {bp[63], bp} + 65'(cw[22]);
        e_f   = u_sum[63:0];
        c     = u_sum[64];
        v     = (s_sum[64] != s_sum[63]);
      end
      3'd3: e_f = ap ^ bp;
      3'd4: e_f = ap << bp[5:0];
      3'd5: e_f = ap >> bp[5:0];
      default: e_f = ap;
    endcase
    e_stat  = {v, c, e_f[63], (e_f == 64'd0)};
    e_drive = cw[24] | cw[23];
    if (cw[24])                e_bus = e_f;
    else if (cw[23] && !cw[25]) e_bus = mram[e_f[7:0]];
    else if (cw[23])           e_bus = e_rb;
    else                       e_bus = ext;
    e_cw = cw;
  endtask

  task automatic modelEdge();
    if (!e_rst) begin
      for (int i = 0; i < 31; i++) mx[i] = 64'd0;
    end else if (e_cw[15] && (e_cw[4:0] != 5'd31)) begin
      mx[e_cw[4:0]] = e_bus;
    end
    if (e_cw[23] && e_cw[25]) begin
      mram[e_f[7:0]]   = e_rb;
      mvalid[e_f[7:0]] = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Drive one cycle's inputs away from the rising edge
  task automatic applyStimulus(input logic [31:0] cw, input logic [63:0] k,
                               input logic rst, input logic [63:0] ext);
    @(negedge clock);
    control_word = cw;
    constant_k   = k;
    reset        = rst;
    e_rst        = rst;
    modelComb(cw, k, ext);
    tb_drive_en  = !e_drive;
    tb_drive_val = ext;
    #1;
  endtask

  task automatic advance();
    modelEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_r%0d", tag, i), 64'(rv[i]), 64'(mx[i][15:0]));
    end
  endtask

  typedef struct {
    logic [31:0] cw;
    logic [63:0] k;
    logic [3:0]  exp_stat;
    logic [31:0] exp_addr;
    logic        chk_bus;
    logic [63:0] exp_bus;
    int          reg_idx;
    logic [15:0] exp_reg;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    passes       = 0;
    checks       = 0;
    reset        = 1'b0;
    control_word = 32'd0;
    constant_k   = 64'd0;
    tb_drive_en  = 1'b1;
    tb_drive_val = 64'd0;
    for (int i = 0; i < 32; i++) mx[i] = 64'd0;
    for (int i = 0; i < 256; i++) begin
      mram[i]   = 64'd0;
      mvalid[i] = 1'b0;
    end

    vecs[0] = '{mk_cw(0, 31, 0, 1, 1, 5'b00100, 0, 0, 1, 0), 64'd24, 4'b0000, 32'd24, 1'b1, 64'd24, 0, 16'h0018};
    vecs[1] = '{mk_cw(1, 31, 0, 1, 0, 5'b01001, 1, 0, 1, 0), 64'd24, 4'b0010, 32'hFFFF_FFE8, 1'b1, 64'hFFFF_FFFF_FFFF_FFE8, 1, 16'hFFE8};
    vecs[2] = '{mk_cw(7, 31, 0, 1, 1, 5'b01000, 0, 0, 1, 0), 64'd24, 4'b0000, 32'd24, 1'b1, 64'd24, 7, 16'h0018};
    vecs[3] = '{mk_cw(0, 7, 1, 0, 0, 5'b11000, 0, 1, 0, 1), 64'd24, 4'b0000, 32'd24, 1'b1, 64'hFFFF_FFFF_FFFF_FFE8, 1, 16'hFFE8};
    vecs[4] = '{mk_cw(2, 7, 0, 1, 0, 5'b11000, 0, 1, 0, 0), 64'd24, 4'b0000, 32'd24, 1'b1, 64'hFFFF_FFFF_FFFF_FFE8, 2, 16'hFFE8};
    vecs[5] = '{mk_cw(1, 0, 1, 1, 0, 5'b00000, 0, 0, 1, 0), 64'd24, 4'b0000, 32'd8, 1'b1, 64'd8, 1, 16'h0008};
    vecs[6] = '{mk_cw(31, 31, 0, 1, 1, 5'b00100, 0, 0, 1, 0), 64'd24, 4'b0000, 32'd24, 1'b1, 64'd24, 0, 16'h0018};
    vecs[7] = '{mk_cw(0, 31, 0, 0, 0, 5'b11000, 0, 0, 1, 0), 64'd24, 4'b0001, 32'd0, 1'b1, 64'd0, 0, 16'h0018};

    // Reset for one edge, then release
    applyStimulus(32'd0, 64'd24, 1'b0, 64'd0);
    advance();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("reset_r%0d", i), 64'(rv[i]), 64'd0);
    end

    // Reference program
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].cw, vecs[v].k, 1'b1, 64'd0);
      checkOutput($sformatf("vec%0d_status", v), 64'(status), 64'(vecs[v].exp_stat));
      checkOutput($sformatf("vec%0d_address", v), 64'(address), 64'(vecs[v].exp_addr));
      if (vecs[v].chk_bus) begin
        checkOutput($sformatf("vec%0d_data", v), data_bus, vecs[v].exp_bus);
      end
      advance();
      checkOutput($sformatf("vec%0d_reg", v), 64'(rv[vecs[v].reg_idx]), 64'(vecs[v].exp_reg));
    end

    // Store during a reset cycle lands, while reset overrides RW
    applyStimulus(mk_cw(5, 31, 0, 1, 1, 5'b00100, 0, 0, 1, 0), 64'd40, 1'b1, 64'd0);
    advance();
    checkOutput("seq_x5_set", 64'(r5), 64'h28);
    applyStimulus(mk_cw(6, 5, 5, 1, 0, 5'b11000, 0, 1, 0, 1), 64'd40, 1'b0, 64'd0);
    checkOutput("seq_rst_store_addr", 64'(address), 64'd40);
    checkOutput("seq_rst_store_data", data_bus, 64'd40);
    advance();
    checkOutput("seq_rst_r5", 64'(r5), 64'd0);
    checkOutput("seq_rst_r6", 64'(r6), 64'd0);
    applyStimulus(mk_cw(4, 31, 0, 1, 1, 5'b00100, 0, 0, 1, 0), 64'd40, 1'b1, 64'd0);
    advance();
    applyStimulus(mk_cw(2, 4, 0, 1, 0, 5'b11000, 0, 1, 0, 0), 64'd40, 1'b1, 64'd0);
    checkOutput("seq_load_data", data_bus, 64'd40);
    advance();
    checkOutput("seq_load_r2", 64'(r2), 64'h28);

    // External agent drives the floating bus into X3
    applyStimulus(mk_cw(3, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 0), 64'd0, 1'b1, 64'h1234_5678_9ABC_BEEF);
    advance();
    checkOutput("seq_ext_r3", 64'(r3), 64'hBEEF);

    // Randomized control words against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] cw;
      logic [63:0] k, ext;
      logic        rst;
      cw  = $urandom;
      cw[4:0] = 5'($urandom_range(0, 7)) | (($urandom_range(0, 7) == 0) ? 5'd31 : 5'd0);
      k   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      ext = {$urandom, $urandom};
      rst = ($urandom_range(0, 24) != 0);
      modelComb(cw, k, ext);
      if (cw[23] && !cw[25] && !cw[24] && !mvalid[e_f[7:0]]) cw[25] = 1'b1;
      applyStimulus(cw, k, rst, ext);
      checkOutput($sformatf("rnd%0d_status", n), 64'(status), 64'(e_stat));
      checkOutput($sformatf("rnd%0d_address", n), 64'(address), 64'(e_f[31:0]));
      if (e_drive) begin
        checkOutput($sformatf("rnd%0d_data", n), data_bus, e_bus);
      end
      advance();
      checkRegs($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/datapath_with_memory_legv8_core.md
DATAPATH_WITH_MEMORY_LEGV8_CORE -- requirements
Module: Datapath_With_Memory_LEGv8

Interface
REQ-001 SHALL have `clock`, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have `ControlWord`, input, 32 bits: per-cycle microoperation (fields below).
REQ-004 SHALL have `data`, inout, 64 bits: shared tri-state data bus; it is the register-file write-data source.
REQ-005 SHALL have `address`, output, 32 bits: memory address, equal to the ALU result F[31:0].
REQ-006 SHALL have `constant`, input, 64 bits: immediate operand for the B mux.
REQ-007 SHALL have `status`, output, 4 bits: combinational {V,C,N,Z} of the current ALU result.
REQ-008 SHALL have `r0` to `r7`, outputs, 16 bits each: bits [15:0] of registers X0 to X7.
REQ-009 SHALL use this port order: ControlWord, data, address, reset, clock, constant, status, r0 to r7.

Function
REQ-010 SHALL decode ControlWord as follows:
- [4:0] DA, [9:5] SA, [14:10] SB.
- [15] RW (register write), [16] BS (1 = B operand is constant, 0 = register B).
- [21:17] FS, [22] C0 (adder carry-in).
- [23] MEM_EN, [24] EN_ALU, [25] MW (1 = write, 0 = read).
- [31:26] reserved and ignored.
REQ-011 SHALL implement a 32x64 register file with two combinational read ports (A = X[SA], B = X[SB]).
REQ-012 SHALL always read X31 as zero and SHALL discard writes to X31.
REQ-013 SHALL write `data` into X[DA] at the rising edge when RW=1 and `reset`=1.
REQ-014 SHALL form the ALU inputs A' = FS[1] ? ~A : A and B' = FS[0] ? ~Bm : Bm, where Bm = BS ? constant : B.
REQ-015 SHALL compute F from FS[4:2]:
- 000: A' AND B'
- 001: A' OR B'
- 010: A' + B' + C0 (64-bit)
- 011: A' XOR B'
- 100: A' << B'[5:0]
- 101: A' >> B'[5:0] (logical)
- 110 and 111: F = A'
REQ-016 SHALL derive the status bits as follows:
- Z = (F == 0).
- N = F[63].
- C = carry out of bit 63 when FS[4:2]=010, else 0.
- V = signed overflow of A'+B'+C0 when FS[4:2]=010, else 0.
REQ-017 SHALL include a 256x64 RAM indexed by address[7:0] (word-indexed, no byte lanes, upper address bits ignored).
REQ-018 SHALL write X[SB] into RAM[address[7:0]] at the rising edge when MEM_EN=1 and MW=1 (write data is the register B read port, never the constant).
REQ-019 SHALL read the RAM combinationally, so a load completes in the same cycle.
REQ-020 SHALL drive the `data` bus as follows, in priority order:
- F when EN_ALU=1.
- Otherwise RAM[address[7:0]] when MEM_EN=1 and MW=0.
- Otherwise X[SB] when MEM_EN=1 and MW=1.
- Otherwise high-Z, so an external agent may drive the bus.
REQ-021 SHALL write whatever value is on the bus when RW=1 with no internal driver active; that value is bench-defined.
REQ-022 SHALL perform a register write and a memory write in the same cycle if both are commanded, both using pre-edge values.
REQ-023 SHALL make all outputs other than the registered r0 to r7 purely combinational.

Reset
REQ-024 SHALL clear X0 to X30 to 0 at a rising edge with `reset`=0; r0 to r7 therefore read 0 after that edge.
REQ-025 SHALL suppress all register writes while `reset`=0, and reset SHALL override RW.
REQ-026 SHALL NOT clear the RAM on reset, and RAM contents are undefined until written.
REQ-027 SHALL still let a memory write commanded during a reset cycle take effect.

Verification (constant = 24 unless stated)
REQ-028 Reset: hold `reset`=0 for 1 edge, then release -> r0 to r7 = 0x0000.
REQ-029 X0 <- X31 | K, with DA=0, SA=31, BS=1, FS=00100, RW=1, EN_ALU=1 -> r0 = 0x0018, status = 0000.
REQ-030 X1 <- X31 - X0, with DA=1, SA=31, SB=0, FS=01001, C0=1, RW=1, EN_ALU=1 -> r1 = 0xFFE8, N=1, Z=0, C=0, V=0.
REQ-031 Store: X7 <- X31 + K (FS=01000, BS=1) gives r7 = 0x0018; then SA=7, SB=1, FS=11000, MEM_EN=1, MW=1, RW=0 -> address = 24, data = 0xFFFF_FFFF_FFFF_FFE8, RAM[24] updated.
REQ-032 Load: SA=7, FS=11000, MEM_EN=1, MW=0, RW=1, DA=2, EN_ALU=0 -> r2 = 0xFFE8 after the edge.
REQ-033 X1 <- X0 & X1 (FS=00000) -> r1 = 0x0008.
REQ-034 Write DA=31 with F = 24, then read SA=31 with FS=11000 -> F = 0 and Z=1.
